// File: rtl/decoder_scan_sequencer_pkg.sv
// Shared types and constants for the decoder scan sequencer.
package decoder_scan_pkg;

    localparam int LINES = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Output values while in reset (also the idle presentation).
    localparam logic [IDX_W-1:0] RST_ADDR   = '0;
    localparam logic             RST_ENABLE = 1'b1;
    localparam logic             RST_BUSY   = 1'b0;
    localparam logic             RST_DONE   = 1'b0;

endpackage

// File: rtl/decoder_scan_sequencer_if.sv
// Request and decoder-side signals of the scan sequencer.
interface decoder_scan_sequencer_if #(
    parameter int DWELL_W = 4
);
    logic               start;
    logic               stop;
    logic [7:0]         mask;
    logic [DWELL_W-1:0] dwell;
    logic               a2;
    logic               a1;
    logic               a0;
    logic               enable;
    logic               busy;
    logic               done;

    // Requester side: issues scans, observes decoder drive and status.
    modport master (
        output start, stop, mask, dwell,
        input  a2, a1, a0, enable, busy, done
    );

    // Sequencer side.
    modport slave (
        input  start, stop, mask, dwell,
        output a2, a1, a0, enable, busy, done
    );
endinterface

// File: rtl/decoder_scan_sequencer_next_line_finder.sv
// Finds the next set mask bit strictly above idx; with first=1 idx is
// treated as -1, giving the lowest set bit.
module next_line_finder
    import decoder_scan_pkg::*;
(
    input  logic [LINES-1:0] mask,
    input  logic [IDX_W-1:0] idx,
    input  logic             first,
    output logic [IDX_W-1:0] nxt,
    output logic             found
);

    // Lowest qualifying bit wins; the found guard blocks later overwrites.
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < LINES; i++) begin
            if (!found && mask[i] && (first || (IDX_W'(i) > idx))) begin
                nxt   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Walks the 3-to-8 decoder address through the enabled lines of a mask,
// holding each for dwell+1 cycles, with a one-cycle done pulse at the end.
module decoder_scan_sequencer
    import decoder_scan_pkg::*;
#(
    parameter int DWELL_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    decoder_scan_sequencer_if.slave  bus
);

    state_t             state, state_n;
    logic [LINES-1:0]   mask_q, mask_q_n;
    logic [DWELL_W-1:0] dwell_q, dwell_q_n;
    logic [DWELL_W-1:0] cnt, cnt_n;
    logic [IDX_W-1:0]   idx, idx_n;

    logic [IDX_W-1:0]   addr_r, addr_n;
    logic               enable_r, enable_n;
    logic               busy_r, busy_n;
    logic               done_r, done_n;

    logic [LINES-1:0]   find_mask;
    logic               find_first;
    logic [IDX_W-1:0]   find_idx;
    logic               find_ok;

    // One finder serves both start (lowest bit of the live mask) and
    // advance (next bit of the latched mask).
    assign find_mask  = (state == IDLE) ? bus.mask : mask_q;
    assign find_first = (state == IDLE);

    next_line_finder u_finder (
        .mask  (find_mask),
        .idx   (idx),
        .first (find_first),
        .nxt   (find_idx),
        .found (find_ok)
    );

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            mask_q   <= '0;
            dwell_q  <= '0;
            cnt      <= '0;
            idx      <= '0;
            addr_r   <= RST_ADDR;
            enable_r <= RST_ENABLE;
            busy_r   <= RST_BUSY;
            done_r   <= RST_DONE;
        end else begin
            state    <= state_n;
            mask_q   <= mask_q_n;
            dwell_q  <= dwell_q_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            addr_r   <= addr_n;
            enable_r <= enable_n;
            busy_r   <= busy_n;
            done_r   <= done_n;
        end
    end

    // Next-state logic; outputs are decoded from the next state and index
    // so the registered outputs line up with the state they describe.
    always_comb begin
        state_n   = state;
        mask_q_n  = mask_q;
        dwell_q_n = dwell_q;
        cnt_n     = cnt;
        idx_n     = idx;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.mask != '0) begin
                        mask_q_n  = bus.mask;
                        dwell_q_n = bus.dwell;
                        idx_n     = find_idx;
                        cnt_n     = bus.dwell;
                        state_n   = SCAN;
                    end else begin
                        state_n   = DONE;
                    end
                end
            end
            SCAN: begin
                if (bus.stop) begin
                    idx_n   = '0;
                    state_n = IDLE;
                end else if (cnt != '0) begin
                    cnt_n = cnt - DWELL_W'(1);
                end else if (find_ok) begin
                    idx_n = find_idx;
                    cnt_n = dwell_q;
                end else begin
                    idx_n   = '0;
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                idx_n   = '0;
                state_n = IDLE;
            end
        endcase

        addr_n   = (state_n == SCAN) ? idx_n : RST_ADDR;
        enable_n = (state_n != SCAN);
        busy_n   = (state_n == SCAN) || (state_n == DONE);
        done_n   = (state_n == DONE);
    end

    assign {bus.a2, bus.a1, bus.a0} = addr_r;
    assign bus.enable = enable_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;

endmodule
